// File: rtl/adder_op_sequencer.sv
// -----------------------------------------------------------------------------
// adder_op_sequencer
//
// Steps a user through loading the two operands and the carry-in of an
// external 4-bit adder with a single pushbutton, then captures and holds the
// adder's result for display.
//
// Each press of the button advances the sequence:
//   S_A    : press loads op_a from sw
//   S_B    : press loads op_b from sw
//   S_CIN  : press loads op_cin from cin_sw
//   S_ADD  : one-cycle settle; result is captured on the exit edge
//   S_SHOW : result held with result_valid high; press returns to S_A
//
// The pushbutton is asynchronous and bouncy. It goes through a two-flop
// synchronizer, then a stability counter that accepts a new level only after
// DEBOUNCE_CYCLES consecutive cycles at that level. The press event is a
// single-cycle pulse on the accepted 1->0 (press) transition.
//
// Ports
//   clk          system clock, rising edge
//   rst_n        asynchronous active-low reset
//   sw[3:0]      raw operand switches
//   cin_sw       raw carry-in switch
//   key_n        raw pushbutton, active-low
//   op_a[3:0]    registered operand A to the external adder
//   op_b[3:0]    registered operand B to the external adder
//   op_cin       registered carry-in to the external adder
//   sum_in[3:0]  combinational sum from the external adder
//   cout_in      combinational carry-out from the external adder
//   result_sum   captured sum
//   result_cout  captured carry-out
//   result_valid high while a captured result is displayed
//   state[2:0]   current FSM encoding
// -----------------------------------------------------------------------------
module adder_op_sequencer #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] sw,
  input  logic       cin_sw,
  input  logic       key_n,
  output logic [3:0] op_a,
  output logic [3:0] op_b,
  output logic       op_cin,
  input  logic [3:0] sum_in,
  input  logic       cout_in,
  output logic [3:0] result_sum,
  output logic       result_cout,
  output logic       result_valid,
  output logic [2:0] state
);

  // The counter only has to reach DEBOUNCE_CYCLES-1, then the level flips.
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_A    = 3'd0,
    S_B    = 3'd1,
    S_CIN  = 3'd2,
    S_ADD  = 3'd3,
    S_SHOW = 3'd4
  } state_t;

  logic             key_sync_p0;
  logic             key_sync_p1;
  logic [CNT_W-1:0] stab_cnt;
  logic             key_db;
  logic             press_q;
  logic             key_press;
  state_t           state_q;

  // Stage p0/p1: two-flop synchronizer for the asynchronous pushbutton.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      key_sync_p0 <= 1'b0;
      key_sync_p1 <= 1'b0;
    end else begin
      key_sync_p0 <= key_n;
      key_sync_p1 <= key_sync_p0;
    end
  end

  // Debounce stage: count consecutive cycles where the synchronized key
  // disagrees with the accepted level; any agreement restarts the count.
  // The press pulse is raised on the same edge the level is accepted low,
  // so it lasts exactly one cycle and a release never produces one.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stab_cnt <= '0;
      key_db   <= 1'b1;
      press_q  <= 1'b0;
    end else begin
      press_q <= 1'b0;
      if (key_sync_p1 != key_db) begin
        if (stab_cnt == CNT_MAX) begin
          key_db   <= key_sync_p1;
          stab_cnt <= '0;
          press_q  <= ~key_sync_p1;
        end else begin
          stab_cnt <= stab_cnt + 1'b1;
        end
      end else begin
        stab_cnt <= '0;
      end
    end
  end

  assign key_press = press_q;

  // Sequencer stage: switches are sampled only on the press edge of the
  // state that owns them, so switch activity elsewhere is invisible.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_A;
      op_a         <= '0;
      op_b         <= '0;
      op_cin       <= 1'b0;
      result_sum   <= '0;
      result_cout  <= 1'b0;
      result_valid <= 1'b0;
    end else begin
      case (state_q)
        S_A: begin
          if (key_press) begin
            op_a    <= sw;
            state_q <= S_B;
          end
        end
        S_B: begin
          if (key_press) begin
            op_b    <= sw;
            state_q <= S_CIN;
          end
        end
        S_CIN: begin
          if (key_press) begin
            op_cin  <= cin_sw;
            state_q <= S_ADD;
          end
        end
        // One cycle for the external adder to settle on the new operands;
        // presses here are dropped rather than queued.
        S_ADD: begin
          result_sum   <= sum_in;
          result_cout  <= cout_in;
          result_valid <= 1'b1;
          state_q      <= S_SHOW;
        end
        S_SHOW: begin
          if (key_press) begin
            result_valid <= 1'b0;
            state_q      <= S_A;
          end
        end
        default: begin
          state_q <= S_A;
        end
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_adder_op_sequencer.sv
module tb_adder_op_sequencer;

  localparam int DB = 4;

  logic       clk;
  logic       rst_n;
  logic [3:0] sw;
  logic       cin_sw;
  logic       key_n;
  logic [3:0] op_a;
  logic [3:0] op_b;
  logic       op_cin;
  logic [3:0] sum_in;
  logic       cout_in;
  logic [3:0] result_sum;
  logic       result_cout;
  logic       result_valid;
  logic [2:0] state;
  logic [4:0] add_res;

  int checks = 0;
  int errors = 0;

  adder_op_sequencer #(.DEBOUNCE_CYCLES(DB)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sw          (sw),
    .cin_sw      (cin_sw),
    .key_n       (key_n),
    .op_a        (op_a),
    .op_b        (op_b),
    .op_cin      (op_cin),
    .sum_in      (sum_in),
    .cout_in     (cout_in),
    .result_sum  (result_sum),
    .result_cout (result_cout),
    .result_valid(result_valid),
    .state       (state)
  );

  // External 4-bit adder model
  assign add_res = {1'b0, op_a} + {1'b0, op_b} + {4'b0000, op_cin};
  assign sum_in  = add_res[3:0];
  assign cout_in = add_res[4];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, errors so far %0d", errors);
    $fatal(1, "watchdog");
  end

  typedef struct packed {
    logic [3:0] a;
    logic [3:0] b;
    logic       cin;
    logic [3:0] sum;
    logic       cout;
  } vec_t;

  vec_t vecs [6];

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Clean press: hold low well past the debounce window, then release.
  task automatic press(input logic [3:0] v, input logic c);
    sw     = v;
    cin_sw = c;
    key_n  = 1'b0;
    tick(10);
    key_n  = 1'b1;
    tick(10);
  endtask

  // Hold the key low until the FSM is seen in S_ADD (bounded).
  task automatic press_until_add(input logic c);
    int n;
    cin_sw = c;
    key_n  = 1'b0;
    n = 0;
    while (state !== 3'd3 && n < 40) begin
      tick(1);
      n++;
    end
  endtask

  initial begin
    vecs[0] = '{a: 4'd9,  b: 4'd8,  cin: 1'b1, sum: 4'd2,  cout: 1'b1};
    vecs[1] = '{a: 4'd15, b: 4'd15, cin: 1'b1, sum: 4'd15, cout: 1'b1};
    vecs[2] = '{a: 4'd7,  b: 4'd8,  cin: 1'b0, sum: 4'd15, cout: 1'b0};
    vecs[3] = '{a: 4'd5,  b: 4'd3,  cin: 1'b1, sum: 4'd9,  cout: 1'b0};
    vecs[4] = '{a: 4'd15, b: 4'd0,  cin: 1'b1, sum: 4'd0,  cout: 1'b1};
    vecs[5] = '{a: 4'd6,  b: 4'd9,  cin: 1'b0, sum: 4'd15, cout: 1'b0};

    rst_n  = 1'b0;
    key_n  = 1'b1;
    sw     = 4'd0;
    cin_sw = 1'b0;
    tick(3);

    chk("reset_state", 8'(state), 8'd0);
    chk("reset_op_a", 8'(op_a), 8'd0);
    chk("reset_op_b", 8'(op_b), 8'd0);
    chk("reset_op_cin", 8'(op_cin), 8'd0);
    chk("reset_result_sum", 8'(result_sum), 8'd0);
    chk("reset_result_cout", 8'(result_cout), 8'd0);
    chk("reset_result_valid", 8'(result_valid), 8'd0);

    rst_n = 1'b1;
    tick(10);
    chk("idle_after_reset_state", 8'(state), 8'd0);

    // Table-driven full sequences with latency check on the carry-in press
    for (int i = 0; i < 6; i++) begin
      press(vecs[i].a, 1'b0);
      chk($sformatf("v%0d_state_b", i), 8'(state), 8'd1);
      chk($sformatf("v%0d_op_a", i), 8'(op_a), 8'(vecs[i].a));
      press(vecs[i].b, 1'b0);
      chk($sformatf("v%0d_state_cin", i), 8'(state), 8'd2);
      chk($sformatf("v%0d_op_b", i), 8'(op_b), 8'(vecs[i].b));
      press_until_add(vecs[i].cin);
      chk($sformatf("v%0d_state_add", i), 8'(state), 8'd3);
      chk($sformatf("v%0d_valid_in_add", i), 8'(result_valid), 8'd0);
      tick(1);
      chk($sformatf("v%0d_state_show", i), 8'(state), 8'd4);
      chk($sformatf("v%0d_valid", i), 8'(result_valid), 8'd1);
      chk($sformatf("v%0d_sum", i), 8'(result_sum), 8'(vecs[i].sum));
      chk($sformatf("v%0d_cout", i), 8'(result_cout), 8'(vecs[i].cout));
      chk($sformatf("v%0d_op_cin", i), 8'(op_cin), 8'(vecs[i].cin));
      key_n = 1'b1;
      sw    = ~vecs[i].a;
      tick(10);
      chk($sformatf("v%0d_hold_state", i), 8'(state), 8'd4);
      chk($sformatf("v%0d_hold_sum", i), 8'(result_sum), 8'(vecs[i].sum));
      press(4'hA, 1'b1);
      chk($sformatf("v%0d_back_state", i), 8'(state), 8'd0);
      chk($sformatf("v%0d_back_valid", i), 8'(result_valid), 8'd0);
      chk($sformatf("v%0d_kept_sum", i), 8'(result_sum), 8'(vecs[i].sum));
    end

    // Asynchronous reset while in S_CIN
    press(4'd15, 1'b0);
    press(4'd15, 1'b0);
    chk("pre_rst_state", 8'(state), 8'd2);
    chk("pre_rst_op_a", 8'(op_a), 8'd15);
    chk("pre_rst_op_b", 8'(op_b), 8'd15);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_state", 8'(state), 8'd0);
    chk("arst_op_a", 8'(op_a), 8'd0);
    chk("arst_op_b", 8'(op_b), 8'd0);
    chk("arst_result_sum", 8'(result_sum), 8'd0);
    chk("arst_result_valid", 8'(result_valid), 8'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tick(10);

    // Bouncing key: 20 cycles of 2-cycle toggles, then a clean hold
    sw = 4'd6;
    for (int i = 0; i < 5; i++) begin
      key_n = 1'b0;
      tick(2);
      key_n = 1'b1;
      tick(2);
    end
    chk("bounce_no_event_state", 8'(state), 8'd0);
    chk("bounce_no_event_op_a", 8'(op_a), 8'd0);
    key_n = 1'b0;
    tick(10);
    key_n = 1'b1;
    tick(10);
    chk("bounce_one_event_state", 8'(state), 8'd1);
    chk("bounce_op_a", 8'(op_a), 8'd6);

    // Switch activity in S_B without a press
    for (int i = 0; i < 10; i++) begin
      sw     = 4'(i * 7 + 3);
      cin_sw = i[0];
      tick(1);
    end
    chk("sw_toggle_op_b", 8'(op_b), 8'd0);
    chk("sw_toggle_op_a", 8'(op_a), 8'd6);
    chk("sw_toggle_state", 8'(state), 8'd1);
    press(4'd7, 1'b0);
    press(4'd0, 1'b1);
    tick(2);
    chk("seq_sum_14", 8'(result_sum), 8'd14);
    chk("seq_cout_14", 8'(result_cout), 8'd0);
    press(4'd0, 1'b0);
    chk("seq_back_state", 8'(state), 8'd0);

    // Zero sequence and wrap back to S_A
    press(4'd0, 1'b0);
    press(4'd0, 1'b0);
    press(4'd0, 1'b0);
    chk("zero_state", 8'(state), 8'd4);
    chk("zero_valid", 8'(result_valid), 8'd1);
    chk("zero_sum", 8'(result_sum), 8'd0);
    chk("zero_cout", 8'(result_cout), 8'd0);
    press(4'd5, 1'b1);
    chk("wrap_state", 8'(state), 8'd0);
    chk("wrap_valid", 8'(result_valid), 8'd0);
    chk("wrap_op_a", 8'(op_a), 8'd0);
    chk("wrap_op_b", 8'(op_b), 8'd0);

    // Press event injected while in S_ADD must be dropped
    press(4'd1, 1'b0);
    press(4'd2, 1'b0);
    press_until_add(1'b1);
    chk("inj_state_add", 8'(state), 8'd3);
    force dut.key_press = 1'b1;
    tick(1);
    release dut.key_press;
    chk("inj_state_show", 8'(state), 8'd4);
    chk("inj_valid", 8'(result_valid), 8'd1);
    chk("inj_sum", 8'(result_sum), 8'd4);
    tick(4);
    chk("inj_still_show", 8'(state), 8'd4);
    key_n = 1'b1;
    tick(10);
    chk("inj_after_release", 8'(state), 8'd4);
    press(4'd0, 1'b0);
    chk("inj_return_state", 8'(state), 8'd0);
    chk("inj_return_valid", 8'(result_valid), 8'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
